// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, limits and parameter checks for mem_pipe_ctrl
//
// Holds the response record layout for the default 32-bit configuration,
// the legal parameter limits and the elaboration-time check functions used
// by mem_pipe_ctrl. No ports.
package mem_pkg;

    localparam int RD_LAT_MAX    = 4;
    localparam int RSP_DEPTH_MAX = 16;
    localparam int MEM_DATA_W    = 32;

    // Response record for the default width; instances with another DATA_W
    // declare the same layout locally with their own width.
    typedef struct packed {
        logic [MEM_DATA_W-1:0] rdata;
        logic                  err;
    } mem_rsp_t;

    function automatic bit data_w_ok(input int data_w);
        return (data_w >= 8) && ((data_w % 8) == 0);
    endfunction

    function automatic bit depth_ok(input int depth, input int addr_w);
        return (depth >= 1) && (addr_w >= 1) && (addr_w <= 31) &&
               (longint'(depth) <= (longint'(1) << addr_w));
    endfunction

    function automatic bit rd_lat_ok(input int rd_lat);
        return (rd_lat >= 1) && (rd_lat <= RD_LAT_MAX);
    endfunction

    function automatic bit rsp_depth_ok(input int rsp_depth);
        return (rsp_depth >= 1) && (rsp_depth <= RSP_DEPTH_MAX);
    endfunction

    // Index width for an n-entry structure; never below one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - generic show-ahead FIFO with modulo-DEPTH pointers
//
// Ports:
//   clock, reset_n  rising-edge clock, asynchronous active-low reset
//   push, push_data write side; push while full is dropped unless a pop
//                   happens in the same cycle
//   pop             consume the head entry (ignored while empty)
//   pop_data        head entry, forced to zero while empty
//   empty, full     occupancy flags
//   count           number of stored entries, 0..DEPTH
module mem_rsp_fifo
    import mem_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Zero while empty so the output is defined without resetting storage.
    assign pop_data = empty ? '0 : store[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(push && full && !pop));

endmodule

// File: rtl/mem_pipe_ctrl.sv
// rtl/mem_pipe_ctrl.sv - memory with valid/ready requests, RD_LAT read pipe and in-order responses
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready while credits remain
//   req_write             1 = write, 0 = read
//   req_addr              word address; addresses >= DEPTH are errors
//   req_wdata, req_be     write data and per-byte enables (writes only)
//   rsp_valid/rsp_ready   response handshake, show-ahead
//   rsp_rdata             read data; zero for writes and errors
//   rsp_err               address was out of range
module mem_pipe_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = ptr_w(DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    if (!data_w_ok(DATA_W)) begin : g_bad_data_w
        $error("mem_pipe_ctrl: DATA_W must be a positive multiple of 8");
    end
    if (!depth_ok(DEPTH, ADDR_W)) begin : g_bad_depth
        $error("mem_pipe_ctrl: DEPTH must be 1..2**ADDR_W");
    end
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_pipe_ctrl: RD_LAT must be 1..RD_LAT_MAX");
    end
    if (!rsp_depth_ok(RSP_DEPTH)) begin : g_bad_rsp_depth
        $error("mem_pipe_ctrl: RSP_DEPTH must be 1..RSP_DEPTH_MAX");
    end

    logic [DATA_W-1:0] mem_array [DEPTH];

    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    rsp_t              sample;

    logic [RD_LAT-1:0] pipe_valid;
    rsp_t              pipe_rsp [RD_LAT];

    logic [CNT_W-1:0]  outstanding;
    logic              rsp_pop;
    logic              rsp_push;
    rsp_t              head;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CNT_W-1:0]  fifo_count;

    // Gating with reset_n keeps requests seen during reset away from the
    // array, which has no reset of its own.
    assign accept    = req_valid && req_ready && reset_n;
    assign req_ready = (outstanding < CNT_W'(RSP_DEPTH));
    assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    assign idx       = req_addr[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (accept && req_write && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem_array[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // The response for this request as it would look if captured now; the
    // array is read with its pre-edge contents, so a write committed on an
    // earlier edge is visible.
    always_comb begin
        sample       = '0;
        sample.err   = !in_range;
        if (in_range && !req_write) begin
            sample.rdata = mem_array[idx];
        end
    end

    // Stage 0 captures on the accept edge; stages 1..RD_LAT-1 delay it so the
    // FIFO push lands on edge accept+RD_LAT.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_rsp[s] <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_rsp[0]   <= sample;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_rsp[s]   <= pipe_rsp[s-1];
            end
        end
    end

    assign rsp_push = pipe_valid[RD_LAT-1];
    assign rsp_pop  = rsp_valid && rsp_ready;

    // Credits cover both the pipeline and the FIFO, so a push always finds room.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({accept, rsp_pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    mem_rsp_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rsp_push),
        .push_data (pipe_rsp[RD_LAT-1]),
        .pop       (rsp_pop),
        .pop_data  (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = head.rdata;
    assign rsp_err   = head.err;

    a_credit_bound: assert property (@(posedge clock) disable iff (!reset_n)
        outstanding <= CNT_W'(RSP_DEPTH));
    a_fifo_within_credit: assert property (@(posedge clock) disable iff (!reset_n)
        fifo_count <= outstanding);
    a_fifo_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(rsp_push && fifo_full && !rsp_pop));

endmodule
